b1_toggle_monitor: RTL and testbench



---
 rtl/b1_toggle_monitor_pkg.sv | 21 ++
 rtl/b1_toggle_monitor_if.sv | 34 +++
 rtl/b1_toggle_monitor_toggle_cnt.sv | 46 ++++
 rtl/b1_toggle_monitor.sv | 148 ++++++++++++++
 tb/tb_b1_toggle_monitor.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/b1_toggle_monitor_pkg.sv
// Shared definitions for the b1 switching-activity monitor: FSM state
// encoding, default geometry and the result-total width helper.
package b1_mon_pkg;

    localparam int MON_WIDTH = 4;
    localparam int MON_CNT_W = 16;
    localparam int MON_WIN_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_ACCUM,
        ST_REPORT
    } mon_state_t;

    // Width that holds the sum of WIDTH counters of cnt_w bits without overflow.
    function automatic int total_w(input int width, input int cnt_w);
        return cnt_w + $clog2(width + 1);
    endfunction

endpackage

// File: rtl/b1_toggle_monitor_if.sv
// Control, sample and result signals between the monitored-netlist side
// (master) and the toggle monitor (slave).
interface b1_toggle_monitor_if
    import b1_mon_pkg::*;
#(
    parameter int WIDTH = MON_WIDTH,
    parameter int CNT_W = MON_CNT_W,
    parameter int WIN_W = MON_WIN_W
) ();

    localparam int TOT_W = total_w(WIDTH, CNT_W);

    logic                   start;
    logic [WIN_W-1:0]       win_len;
    logic                   in_valid;
    logic [WIDTH-1:0]       in_vec;
    logic                   busy;
    logic                   res_valid;
    logic                   res_ready;
    logic [WIDTH*CNT_W-1:0] res_cnt;
    logic [TOT_W-1:0]       res_total;
    logic [WIN_W-1:0]       res_samples;

    modport master (
        output start, win_len, in_valid, in_vec, res_ready,
        input  busy, res_valid, res_cnt, res_total, res_samples
    );

    modport slave (
        input  start, win_len, in_valid, in_vec, res_ready,
        output busy, res_valid, res_cnt, res_total, res_samples
    );

endinterface

// File: rtl/b1_toggle_monitor_toggle_cnt.sv
// Per-bit toggle counter. Exposes the value the counter takes at the next
// edge so the parent can capture final counts on the same edge as the
// last increment.
// Build option: TOGGLE_MON_SATURATE_EN makes the counter saturate at all
// ones instead of wrapping.
module toggle_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic             differ,
    output logic [CNT_W-1:0] cnt_nxt
);

    logic [CNT_W-1:0] cnt_q;

    // Next count: clear wins, otherwise count a toggle on an enabled sample.
    always_comb begin
        // NOTE: default first so every path assigns cnt_nxt and no latch is inferred.
        cnt_nxt = cnt_q;
        if (clear) begin
            cnt_nxt = '0;
        end else if (en && differ) begin
`ifdef TOGGLE_MON_SATURATE_EN
            if (cnt_q != '1) begin
                cnt_nxt = cnt_q + CNT_W'(1);
            end
`else
            cnt_nxt = cnt_q + CNT_W'(1);
`endif
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so all registers update together at the edge.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_nxt;
        end
    end

endmodule

// File: rtl/b1_toggle_monitor.sv
// Switching-activity monitor for the b1 netlist outputs {g,f,e,d}. Counts
// per-bit toggles over a window of valid samples and reports per-bit
// counts, their total and the sample count through a valid/ready handshake.
// Build option: TOGGLE_MON_SATURATE_EN (saturating per-bit counters,
// see toggle_cnt).
module b1_toggle_monitor
    import b1_mon_pkg::*;
#(
    parameter int WIDTH = MON_WIDTH,
    parameter int CNT_W = MON_CNT_W,
    parameter int WIN_W = MON_WIN_W
) (
    input logic                 clk,
    input logic                 rst,
    b1_toggle_monitor_if.slave  bus
);

    localparam int TOT_W = total_w(WIDTH, CNT_W);

    mon_state_t             state_q;
    mon_state_t             state_nxt;
    logic [WIN_W-1:0]       win_len_q;
    logic [WIN_W-1:0]       sample_cnt_q;
    logic [WIN_W-1:0]       sample_cnt_inc;
    logic [WIDTH-1:0]       prev_q;
    logic [CNT_W-1:0]       cnt_nxt [WIDTH];
    logic [TOT_W-1:0]       total_nxt;
    logic [WIDTH*CNT_W-1:0] res_cnt_q;
    logic [TOT_W-1:0]       res_total_q;
    logic [WIN_W-1:0]       res_samples_q;

    logic start_acc;
    logic arm_take;
    logic accum_en;
    logic last_sample;
    logic enter_report;

    assign start_acc      = (state_q == ST_IDLE) && bus.start;
    assign arm_take       = (state_q == ST_ARM) && bus.in_valid;
    assign accum_en       = (state_q == ST_ACCUM) && bus.in_valid;
    assign sample_cnt_inc = sample_cnt_q + WIN_W'(1);
    assign last_sample    = accum_en && (sample_cnt_inc == win_len_q);
    assign enter_report   = (state_nxt == ST_REPORT) && (state_q != ST_REPORT);

    // One toggle counter per monitored bit; cleared when a measurement starts.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cnt
        toggle_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .clear   (start_acc),
            .en      (accum_en),
            .differ  (bus.in_vec[i] ^ prev_q[i]),
            .cnt_nxt (cnt_nxt[i])
        );
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // FSM next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.win_len == '0) ? ST_REPORT : ST_ARM;
                end
            end
            ST_ARM: begin
                if (bus.in_valid) begin
                    state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (last_sample) begin
                    state_nxt = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (bus.res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs depend on the state register only.
    always_comb begin
        bus.busy      = (state_q != ST_IDLE);
        bus.res_valid = (state_q == ST_REPORT);
    end

    // Window bookkeeping: captured length, sample counter and reference sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_len_q    <= '0;
            sample_cnt_q <= '0;
            prev_q       <= '0;
        end else begin
            if (start_acc) begin
                win_len_q    <= bus.win_len;
                sample_cnt_q <= '0;
            end
            if (arm_take) begin
                prev_q <= bus.in_vec;
            end
            if (accum_en) begin
                prev_q       <= bus.in_vec;
                sample_cnt_q <= sample_cnt_inc;
            end
        end
    end

    // Sum of the final per-bit counts, wide enough never to overflow.
    always_comb begin
        total_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            total_nxt = total_nxt + TOT_W'(cnt_nxt[i]);
        end
    end

    // Result registers, loaded on the edge that enters REPORT and held there.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_cnt_q     <= '0;
            res_total_q   <= '0;
            res_samples_q <= '0;
        end else if (enter_report) begin
            for (int i = 0; i < WIDTH; i++) begin
                res_cnt_q[i*CNT_W +: CNT_W] <= cnt_nxt[i];
            end
            res_total_q   <= total_nxt;
            res_samples_q <= start_acc ? bus.win_len : win_len_q;
        end
    end

    assign bus.res_cnt     = res_cnt_q;
    assign bus.res_total   = res_total_q;
    assign bus.res_samples = res_samples_q;

endmodule

// File: tb/tb_b1_toggle_monitor.sv
// Self-checking bench for b1_toggle_monitor: directed table of windows,
// hand-written reset/backpressure/zero-window/saturation sequences and
// randomized windows checked against a toggle-counting reference model.
module tb_b1_toggle_monitor;
    import b1_mon_pkg::*;

    typedef logic [3:0] vq_t[$];
    typedef int         iq_t[$];

    typedef struct {
        int               wl;
        int               nsmp;
        logic [4:0][3:0]  smp;
        int               gap;
        logic [3:0][15:0] cnt;
        int               total;
        int               lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    b1_toggle_monitor_if #(.WIDTH(4), .CNT_W(16), .WIN_W(16)) bus ();
    b1_toggle_monitor_if #(.WIDTH(4), .CNT_W(4),  .WIN_W(16)) bus_s ();

    b1_toggle_monitor #(.WIDTH(4), .CNT_W(16), .WIN_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    b1_toggle_monitor #(.WIDTH(4), .CNT_W(4), .WIN_W(16)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: count value changes per bit over the first wl+1 samples,
    // then apply the counter's overflow rule.
    task automatic model(input vq_t smp, input int wl, input int cw,
                         output logic [63:0] cnt, output int total);
        int t;
        int maxv;
        maxv  = (1 << cw) - 1;
        cnt   = '0;
        total = 0;
        for (int b = 0; b < 4; b++) begin
            t = 0;
            for (int i = 1; i <= wl; i++) begin
                if (smp[i][b] !== smp[i-1][b]) t++;
            end
`ifdef TOGGLE_MON_SATURATE_EN
            if (t > maxv) t = maxv;
`else
            t = t % (maxv + 1);
`endif
            cnt   = cnt | (64'(t) << (b * cw));
            total = total + t;
        end
    endtask

    // Starts a window and feeds samples, each preceded by gap[j] idle cycles.
    // Entered and left #1 after a rising edge. lat counts cycles from the
    // start cycle to the first cycle with res_valid high.
    task automatic run_meas(input int wl, input vq_t smp, input iq_t gap,
                            output int lat, output bit early);
        early        = 1'b0;
        bus.start    = 1'b1;
        bus.win_len  = 16'(wl);
        bus.in_valid = 1'b0;
        @(posedge clk);
        lat = 1;
        #1;
        bus.start = 1'b0;
        for (int j = 0; j < smp.size(); j++) begin
            repeat (gap[j]) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                lat++;
                #1;
                if (bus.res_valid) early = 1'b1;
            end
            bus.in_valid = 1'b1;
            bus.in_vec   = smp[j];
            @(posedge clk);
            lat++;
            #1;
            if (bus.res_valid && j < smp.size() - 1) early = 1'b1;
        end
        bus.in_valid = 1'b0;
        while (!bus.res_valid && lat < 400) begin
            @(posedge clk);
            lat++;
            #1;
        end
    endtask

    task automatic handshake(input string name);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        check({name, " res_valid after ack"}, 64'(bus.res_valid), 64'd0);
        check({name, " busy after ack"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, " busy"}, 64'(bus.busy), 64'd0);
        check({name, " res_valid"}, 64'(bus.res_valid), 64'd0);
        check({name, " res_cnt"}, 64'(bus.res_cnt), 64'd0);
        check({name, " res_total"}, 64'(bus.res_total), 64'd0);
        check({name, " res_samples"}, 64'(bus.res_samples), 64'd0);
        check({name, " state"}, 64'(dut.state_q), 64'(ST_IDLE));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[4];
        vq_t         smp;
        iq_t         gq;
        int          lat;
        bit          early;
        logic [63:0] ecnt;
        int          etot;
        int          elat;
        int          wl;

        tbl[0] = '{wl: 4, nsmp: 5, smp: {4'b1111, 4'b0110, 4'b1001, 4'b1001, 4'b0000},
                   gap: 0, cnt: {16'd3, 16'd1, 16'd1, 16'd3}, total: 8, lat: 6};
        tbl[1] = '{wl: 4, nsmp: 5, smp: {4'b1111, 4'b0110, 4'b1001, 4'b1001, 4'b0000},
                   gap: 2, cnt: {16'd3, 16'd1, 16'd1, 16'd3}, total: 8, lat: 14};
        tbl[2] = '{wl: 2, nsmp: 3, smp: {4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000},
                   gap: 0, cnt: {16'd2, 16'd2, 16'd2, 16'd2}, total: 8, lat: 4};
        tbl[3] = '{wl: 1, nsmp: 2, smp: {4'b0000, 4'b0000, 4'b0000, 4'b0110, 4'b0101},
                   gap: 0, cnt: {16'd0, 16'd0, 16'd1, 16'd1}, total: 2, lat: 3};

        bus.start = 1'b0;     bus.win_len = '0;     bus.in_valid = 1'b0;
        bus.in_vec = '0;      bus.res_ready = 1'b0;
        bus_s.start = 1'b0;   bus_s.win_len = '0;   bus_s.in_valid = 1'b0;
        bus_s.in_vec = '0;    bus_s.res_ready = 1'b0;

        // Power-on reset held for two cycles.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs_zero("por");

        // Reset in the middle of ACCUM discards the measurement.
        bus.start   = 1'b1;
        bus.win_len = 16'd10;
        check("busy before accept", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy after accept", 64'(bus.busy), 64'd1);
        for (int j = 0; j < 3; j++) begin
            bus.in_valid = 1'b1;
            bus.in_vec   = (j % 2 == 0) ? 4'hF : 4'h0;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check("mid state accum", 64'(dut.state_q), 64'(ST_ACCUM));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs_zero("mid reset");

        // Directed windows from the table.
        for (int k = 0; k < 4; k++) begin
            smp = {};
            gq  = {};
            for (int j = 0; j < tbl[k].nsmp; j++) begin
                smp.push_back(tbl[k].smp[j]);
                gq.push_back(j == 0 ? 0 : tbl[k].gap);
            end
            run_meas(tbl[k].wl, smp, gq, lat, early);
            check($sformatf("tbl%0d latency", k), 64'(lat), 64'(tbl[k].lat));
            check($sformatf("tbl%0d early valid", k), 64'(early), 64'd0);
            check($sformatf("tbl%0d res_cnt", k), 64'(bus.res_cnt), 64'(tbl[k].cnt));
            check($sformatf("tbl%0d res_total", k), 64'(bus.res_total), 64'(tbl[k].total));
            check($sformatf("tbl%0d res_samples", k), 64'(bus.res_samples), 64'(tbl[k].wl));
            handshake($sformatf("tbl%0d", k));
        end

        // Backpressure in REPORT with start pulsed: outputs hold, start ignored.
        smp = {4'b0000, 4'b1001, 4'b1001, 4'b0110, 4'b1111};
        gq  = {0, 0, 0, 0, 0};
        run_meas(4, smp, gq, lat, early);
        for (int c = 0; c < 5; c++) begin
            bus.start   = 1'b1;
            bus.win_len = 16'd3;
            @(posedge clk);
            #1;
            check($sformatf("bp%0d res_valid", c), 64'(bus.res_valid), 64'd1);
            check($sformatf("bp%0d res_cnt", c), 64'(bus.res_cnt), 64'h0003_0001_0001_0003);
            check($sformatf("bp%0d res_total", c), 64'(bus.res_total), 64'd8);
            check($sformatf("bp%0d res_samples", c), 64'(bus.res_samples), 64'd4);
        end
        bus.start = 1'b0;
        handshake("bp");
        @(posedge clk);
        #1;
        check("bp start not latched", 64'(bus.busy), 64'd0);

        // Zero-length window: result the cycle after start, nothing counted.
        bus.start    = 1'b1;
        bus.win_len  = 16'd0;
        bus.in_valid = 1'b1;
        bus.in_vec   = 4'hA;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("wl0 res_valid", 64'(bus.res_valid), 64'd1);
        check("wl0 res_cnt", 64'(bus.res_cnt), 64'd0);
        check("wl0 res_total", 64'(bus.res_total), 64'd0);
        check("wl0 res_samples", 64'(bus.res_samples), 64'd0);
        handshake("wl0");
        bus.in_valid = 1'b0;

        // Narrow counters: 20 toggles per bit exceed a 4-bit counter.
        smp = {};
        for (int j = 0; j <= 20; j++) smp.push_back((j % 2 == 1) ? 4'hF : 4'h0);
        model(smp, 20, 4, ecnt, etot);
        bus_s.start   = 1'b1;
        bus_s.win_len = 16'd20;
        @(posedge clk);
        #1;
        bus_s.start = 1'b0;
        for (int j = 0; j <= 20; j++) begin
            bus_s.in_valid = 1'b1;
            bus_s.in_vec   = smp[j];
            @(posedge clk);
            #1;
        end
        bus_s.in_valid = 1'b0;
        check("sat res_valid", 64'(bus_s.res_valid), 64'd1);
        for (int b = 0; b < 4; b++) begin
            check($sformatf("sat res_cnt[%0d]", b), 64'(bus_s.res_cnt[b*4 +: 4]),
                  (ecnt >> (b * 4)) & 64'hF);
        end
        check("sat res_total", 64'(bus_s.res_total), 64'(etot));
        check("sat res_samples", 64'(bus_s.res_samples), 64'd20);
        bus_s.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_s.res_ready = 1'b0;
        check("sat idle after ack", 64'(bus_s.busy), 64'd0);

        // Randomized windows with random valid gaps and response delays.
        for (int it = 0; it < 20; it++) begin
            wl   = $urandom_range(1, 12);
            smp  = {};
            gq   = {};
            elat = 1;
            for (int j = 0; j <= wl; j++) begin
                smp.push_back(4'($urandom_range(0, 15)));
                gq.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
                elat = elat + gq[j] + 1;
            end
            model(smp, wl, 16, ecnt, etot);
            run_meas(wl, smp, gq, lat, early);
            check($sformatf("rnd%0d latency", it), 64'(lat), 64'(elat));
            check($sformatf("rnd%0d early valid", it), 64'(early), 64'd0);
            check($sformatf("rnd%0d res_cnt", it), 64'(bus.res_cnt), ecnt);
            check($sformatf("rnd%0d res_total", it), 64'(bus.res_total), 64'(etot));
            check($sformatf("rnd%0d res_samples", it), 64'(bus.res_samples), 64'(wl));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            handshake($sformatf("rnd%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
